// File: rtl/regbank_read_arbiter_if.sv
// Request/response bundle between the shared register-bank read port,
// its clients and the round-robin read arbiter.
interface regbank_read_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16,
   parameter int SEL_W   = 4
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*SEL_W-1:0] req_sel;
   logic [SEL_W-1:0]         mux_select;
   logic [DATA_W-1:0]        mux_data;
   logic [NUM_REQ-1:0]       gnt;
   logic                     busy;
   logic                     rsp_valid;
   logic [ID_W-1:0]          rsp_id;
   logic [DATA_W-1:0]        rsp_data;

   modport master (
      input  req,
      input  req_sel,
      input  mux_data,
      output mux_select,
      output gnt,
      output busy,
      output rsp_valid,
      output rsp_id,
      output rsp_data
   );

   modport slave (
      output req,
      output req_sel,
      output mux_data,
      input  mux_select,
      input  gnt,
      input  busy,
      input  rsp_valid,
      input  rsp_id,
      input  rsp_data
   );
endinterface

// File: rtl/regbank_read_arbiter.sv
// Round-robin arbiter sharing one 16:1 register-bank read mux among
// NUM_REQ requesters; three cycles per transaction (IDLE/SELECT/CAPTURE).
module regbank_read_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16,
   parameter int SEL_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regbank_read_arbiter_if.master bus
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SW   = ID_W + 1;

   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] SELECT  = 2'b01;
   localparam logic [1:0] CAPTURE = 2'b10;

   localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);
   localparam logic [ID_W-1:0]    ID_LAST = ID_W'(NUM_REQ - 1);

   logic [1:0]         state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0]   mux_select_q, mux_select_d;
   logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
   logic               rsp_valid_q, rsp_valid_d;

   logic [ID_W-1:0]    win;
   logic [SW-1:0]      idx_sum;

   // Rotating-priority search: nearest set req bit at or above rr_ptr
   always_comb begin
      win     = '0;
      idx_sum = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx_sum = {1'b0, rr_ptr_q} + SW'(k);
         if (idx_sum >= SW'(NUM_REQ)) begin
            idx_sum = idx_sum - SW'(NUM_REQ);
         end
         if (bus.req[idx_sum[ID_W-1:0]]) begin
            win = idx_sum[ID_W-1:0];
         end
      end
   end

   // Transaction sequencing and next values of every registered output
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      rsp_id_d     = rsp_id_q;
      gnt_d        = gnt_q;
      mux_select_d = mux_select_q;
      rsp_data_d   = rsp_data_q;
      rsp_valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               gnt_d        = GNT_ONE << win;
               mux_select_d = bus.req_sel[win*SEL_W +: SEL_W];
               rsp_id_d     = win;
               state_d      = SELECT;
            end
         end
         SELECT: begin
            rsp_data_d  = bus.mux_data;
            rsp_valid_d = 1'b1;
            rr_ptr_d    = (rsp_id_q == ID_LAST) ? '0
                                                : rsp_id_q + 1'b1;
            state_d     = CAPTURE;
         end
         CAPTURE: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction silently
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         rsp_id_q     <= '0;
         gnt_q        <= '0;
         mux_select_q <= '0;
         rsp_data_q   <= '0;
         rsp_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         rsp_id_q     <= rsp_id_d;
         gnt_q        <= gnt_d;
         mux_select_q <= mux_select_d;
         rsp_data_q   <= rsp_data_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   assign bus.mux_select = mux_select_q;
   assign bus.gnt        = gnt_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_data   = rsp_data_q;
endmodule

// File: tb/tb_regbank_read_arbiter.sv
// Directed and random checks of regbank_read_arbiter against a
// transaction-level round-robin model.
module tb_regbank_read_arbiter;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int SW = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   regbank_read_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW)) bus ();

   logic [DW-1:0] bank [16];
   assign bus.mux_data = bank[bus.mux_select];

   regbank_read_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int m_rr   = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [N-1:0] r, input int rr);
      int i;
      for (int k = 0; k < N; k++) begin
         i = (rr + k) % N;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic chk_idle(input string tag);
      chk($sformatf("%s.gnt", tag), 32'(bus.gnt), 0);
      chk($sformatf("%s.busy", tag), 32'(bus.busy), 0);
      chk($sformatf("%s.rsp_valid", tag), 32'(bus.rsp_valid), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk_idle(tag);
      chk($sformatf("%s.rsp_id", tag), 32'(bus.rsp_id), 0);
      chk($sformatf("%s.rsp_data", tag), 32'(bus.rsp_data), 0);
      chk($sformatf("%s.mux_select", tag), 32'(bus.mux_select), 0);
   endtask

   // One full transaction starting from idle with req/req_sel already set
   task automatic txn(input string tag, input bit keep, input bit withdraw);
      int w;
      logic [SW-1:0] esel;
      logic [DW-1:0] edata;
      w = pick(bus.req, m_rr);
      if (w < 0) begin
         tick();
         chk_idle(tag);
         return;
      end
      esel = bus.req_sel[w*SW +: SW];
      tick();
      chk($sformatf("%s.sel.gnt", tag), 32'(bus.gnt), 32'(1) << w);
      chk($sformatf("%s.sel.mux", tag), 32'(bus.mux_select), 32'(esel));
      chk($sformatf("%s.sel.busy", tag), 32'(bus.busy), 1);
      chk($sformatf("%s.sel.vld", tag), 32'(bus.rsp_valid), 0);
      chk($sformatf("%s.sel.id", tag), 32'(bus.rsp_id), 32'(w));
      edata = bank[esel];
      if (withdraw) begin
         bus.req = '0;
         bus.req_sel[w*SW +: SW] = 4'hF;
      end
      tick();
      chk($sformatf("%s.cap.vld", tag), 32'(bus.rsp_valid), 1);
      chk($sformatf("%s.cap.id", tag), 32'(bus.rsp_id), 32'(w));
      chk($sformatf("%s.cap.data", tag), 32'(bus.rsp_data), 32'(edata));
      chk($sformatf("%s.cap.gnt", tag), 32'(bus.gnt), 32'(1) << w);
      chk($sformatf("%s.cap.busy", tag), 32'(bus.busy), 1);
      if (!keep) bus.req[w] = 1'b0;
      m_rr = (w + 1) % N;
      tick();
      chk_idle($sformatf("%s.end", tag));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         bank[i] = {i[3:0], 8'h00, i[3:0]};
      end
      bus.req     = '0;
      bus.req_sel = '0;
      rst_n       = 1'b0;
      tick();
      tick();
      chk_zero("reset");
      rst_n = 1'b1;

      for (int c = 0; c < 10; c++) begin
         tick();
         chk_idle("idle");
         chk("idle.mux", 32'(bus.mux_select), 0);
      end

      bus.req          = 4'b0010;
      bus.req_sel[7:4] = 4'hA;
      txn("single", 1'b0, 1'b0);
      chk("single.data", 32'(bus.rsp_data), 32'h0000A00A);

      bus.req     = 4'b1111;
      bus.req_sel = {4'h9, 4'h7, 4'h5, 4'h3};
      rst_n       = 1'b0;
      tick();
      rst_n = 1'b1;
      m_rr  = 0;
      for (int t = 0; t < 6; t++) begin
         txn($sformatf("fair%0d", t), 1'b1, 1'b0);
      end

      bus.req = 4'b0100;
      txn("pre_wrap", 1'b0, 1'b0);
      bus.req = 4'b1001;
      txn("wrap3", 1'b0, 1'b0);
      chk("wrap3.id", 32'(bus.rsp_id), 3);
      txn("wrap0", 1'b0, 1'b0);
      chk("wrap0.id", 32'(bus.rsp_id), 0);

      bus.req           = 4'b0100;
      bus.req_sel[11:8] = 4'h2;
      txn("withdraw", 1'b0, 1'b1);
      chk("withdraw.data", 32'(bus.rsp_data), 32'h00002002);

      bus.req = 4'b0100;
      txn("pre_rst", 1'b0, 1'b0);
      bus.req     = 4'b1100;
      bus.req_sel = {4'h6, 4'h4, 4'h1, 4'h8};
      tick();
      chk("midrst.busy", 32'(bus.busy), 1);
      rst_n = 1'b0;
      tick();
      chk_zero("midrst");
      rst_n = 1'b1;
      m_rr  = 0;
      txn("postrst", 1'b0, 1'b0);
      chk("postrst.id", 32'(bus.rsp_id), 2);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 16; i++) begin
            bank[i] = DW'($urandom);
         end
         bus.req     = N'($urandom_range(0, 15));
         bus.req_sel = (N*SW)'($urandom);
         if (bus.req == '0) begin
            tick();
            chk_idle("rnd_idle");
         end else begin
            txn($sformatf("rnd%0d", r), 1'($urandom),
                ($urandom % 4) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/regbank_read_arbiter.md
Name: regbank_read_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 x 16-bit read mux (256-bit register bank flattened, 4-bit select) among NUM_REQ requesters.
- Each requester asks for one 16-bit word by 4-bit index; the block owns the mux select, captures the mux output, and returns the tagged word.
- Sits between the register bank read mux and the pipeline/debug clients that contend for that read port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ), derived.
- DATA_W, 16, mux output / response width.
- SEL_W, 4, mux select width (16 entries).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_REQ  per-requester request level; held until own response.
- req_sel  input  NUM_REQ*SEL_W  requester i index at [i*SEL_W +: SEL_W].
- mux_select  output  SEL_W  registered select driven to the shared 16:1 mux.
- mux_data  input  DATA_W  combinational mux output for mux_select.
- gnt  output  NUM_REQ  registered one-hot grant; zero when idle.
- busy  output  1  high in SELECT and CAPTURE states.
- rsp_valid  output  1  one-cycle pulse, response valid.
- rsp_id  output  ID_W  index of the requester being answered.
- rsp_data  output  DATA_W  captured word.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; mux_select=0, gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0. Applies from any state and aborts any transaction in flight; no response is issued for it.
- FSM states: IDLE, SELECT, CAPTURE.
- IDLE: if req != 0, pick the winner W = first set bit of req, searching upward from rr_ptr and wrapping modulo NUM_REQ. At the edge: gnt <= onehot(W), mux_select <= req_sel[W], rsp_id <= W, go to SELECT. If req == 0, stay in IDLE; gnt stays 0.
- SELECT: mux_select is stable for the whole cycle. At the edge: rsp_data <= mux_data, rsp_valid <= 1, rr_ptr <= (W+1) mod NUM_REQ, go to CAPTURE.
- CAPTURE: rsp_valid is high for exactly this cycle. At the edge: rsp_valid <= 0, gnt <= 0, go to IDLE.
- Latency: req sampled in IDLE at edge N -> gnt and mux_select valid after N -> rsp_valid high after edge N+1 for one cycle. Three cycles per transaction. Peak rate is one response every 3 cycles.
- Requester handshake: the requester deasserts req in the cycle rsp_valid is high for its id. If req is still high when the FSM returns to IDLE, it is a new request; rr_ptr has already advanced, so it loses to any other pending requester.
- Request withdrawn in SELECT or CAPTURE: the transaction still completes and the response is still issued.
- req_sel changes after the grant are ignored; mux_select is latched in IDLE only.
- Wrap-around: when rr_ptr = NUM_REQ-1, the search order is NUM_REQ-1, 0, 1, and so on. When W = NUM_REQ-1, rr_ptr wraps to 0.
- mux_select and rsp_data hold their last values while idle. Consumers qualify them with rsp_valid and gnt only.
- Invariants: gnt is one-hot or zero; gnt != 0 iff busy; rsp_valid only in CAPTURE; any continuously asserted req is served within NUM_REQ transactions.

Test Plan:
- Reset, then req=0 for 10 cycles -> gnt=0, busy=0, rsp_valid never asserts, mux_select=0.
- Single request: req=4'b0010, req_sel[7:4]=4'hA, mux model returns 16'hA00A for select A -> gnt=0010 and mux_select=A one cycle later; the next cycle has rsp_valid=1, rsp_id=1, rsp_data=16'hA00A; back in IDLE after 3 cycles.
- Fairness: req=4'b1111 held continuously from reset, selects 3,5,7,9 -> grant order 0,1,2,3,0,1, with responses every 3 cycles carrying each requester's own word.
- Wrap: rr_ptr=3 (after serving requester 2), req=4'b1001 -> requester 3 is granted, then requester 0, and rr_ptr wraps to 0.
- Withdraw and change index: req=4'b0100 with sel=4'h2, then in SELECT drop req and set sel=4'hF -> response still issued with id=2 and the word at index 2.
- Reset mid-operation: rst_n=0 in the SELECT cycle -> next edge gives all outputs 0 and state IDLE, no rsp_valid pulse; after release with req=4'b0100, requester 2 is granted first (rr_ptr=0).
